// File: rtl/fetch_sequencer_pkg.sv
// Shared phase codes and fetch FSM state type for the multicycle CPU front end.
// Control decodes the same phase codes to gate MemWrite (MEM) and RegWrite (WB).
package fetch_sequencer_pkg;

  localparam logic [1:0] PHASE_FETCH = 2'b01;
  localparam logic [1:0] PHASE_EXEC  = 2'b10;
  localparam logic [1:0] PHASE_MEM   = 2'b11;
  localparam logic [1:0] PHASE_WB    = 2'b00;
  // HALTED aliases EXEC so control never raises a write strobe while stopped.
  localparam logic [1:0] PHASE_HALT  = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALTED
  } state_e;

  function automatic logic [1:0] phase_of(input state_e s);
    logic [1:0] p;
    case (s)
      ST_FETCH:  p = PHASE_FETCH;
      ST_EXEC:   p = PHASE_EXEC;
      ST_MEM:    p = PHASE_MEM;
      ST_WB:     p = PHASE_WB;
      ST_HALTED: p = PHASE_HALT;
      default:   p = PHASE_FETCH;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux evaluated on the WB edge: jr, then j/jal, then taken branch, else pc+4.
// Purely combinational; all arithmetic wraps modulo 2^PC_WIDTH.
module pc_next_sel #(
  parameter int PC_WIDTH = 32
) (
  input  logic [PC_WIDTH-1:0] pc_plus4,
  input  logic [31:0]         instr,
  input  logic [PC_WIDTH-1:0] rs_value,
  input  logic                branch,
  input  logic                branch_taken,
  input  logic                jump,
  input  logic                pcrs,
  output logic [PC_WIDTH-1:0] next_pc
);

  logic [PC_WIDTH-1:0] jump_target;
  logic [PC_WIDTH-1:0] branch_offset;
  logic [PC_WIDTH-1:0] branch_target;
  logic                unused_opcode;

  // Opcode is decoded upstream by control; only the immediate fields matter here.
  assign unused_opcode = ^instr[31:26];

  assign jump_target   = {pc_plus4[PC_WIDTH-1:28], instr[25:0], 2'b00};
  assign branch_offset = {{(PC_WIDTH-18){instr[15]}}, instr[15:0], 2'b00};
  assign branch_target = pc_plus4 + branch_offset;

  always_comb begin
    next_pc = pc_plus4;
    if (pcrs) begin
      next_pc = rs_value;
    end else if (jump) begin
      next_pc = jump_target;
    end else if (branch && branch_taken) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// PC, instruction register and phase sequencer: FETCH stalls until imem_ready, then EXEC, MEM, WB.
// Minimum 4 cycles per instruction; halt at WB parks the block in HALTED until reset.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_WIDTH = 32
) (
  input  logic                clock,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [31:0]         imem_data,
  input  logic                branch,
  input  logic                branch_taken,
  input  logic                jump,
  input  logic                pcrs,
  input  logic [PC_WIDTH-1:0] rs_value,
  input  logic                halt,
  output logic [31:0]         instr,
  output logic [5:0]          op,
  output logic [1:0]          clock_counter,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus4
);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         instr_q, instr_d;
  logic [PC_WIDTH-1:0] next_pc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC[PC_WIDTH-1:0];
      instr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  pc_next_sel #(
    .PC_WIDTH(PC_WIDTH)
  ) u_pc_next_sel (
    .pc_plus4    (pc_plus4),
    .instr       (instr_q),
    .rs_value    (rs_value),
    .branch      (branch),
    .branch_taken(branch_taken),
    .jump        (jump),
    .pcrs        (pcrs),
    .next_pc     (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ready) begin
          instr_d = imem_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_MEM;
      ST_MEM:  state_d = ST_WB;
      ST_WB: begin
        pc_d    = next_pc;
        state_d = halt ? ST_HALTED : ST_FETCH;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_FETCH;
    endcase
  end

  // The register already sits in FETCH during reset, so the request is masked explicitly.
  assign imem_req      = (state_q == ST_FETCH) && !reset;
  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign pc_plus4      = pc_q + {{(PC_WIDTH-3){1'b0}}, 3'd4};
  assign instr         = instr_q;
  assign op            = instr_q[31:26];
  assign clock_counter = phase_of(state_q);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; inputs change and outputs are sampled on negedge.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic        branch, branch_taken, jump, pcrs, halt;
  logic [31:0] rs_value;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [1:0]  clock_counter;
  logic [31:0] pc, pc_plus4;

  int total = 0;
  int bad   = 0;

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .PC_WIDTH(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_data    (imem_data),
    .branch       (branch),
    .branch_taken (branch_taken),
    .jump         (jump),
    .pcrs         (pcrs),
    .rs_value     (rs_value),
    .halt         (halt),
    .instr        (instr),
    .op           (op),
    .clock_counter(clock_counter),
    .pc           (pc),
    .pc_plus4     (pc_plus4)
  );

  always #5 clock = ~clock;

  // Fetches d from FETCH, runs to WB, applies the control inputs on the WB edge.
  task automatic exec_instr(input logic [31:0] d, input logic br, input logic tk,
                            input logic jmp, input logic prs, input logic [31:0] rsv,
                            input logic hlt);
    int n;
    imem_ready = 1'b1;
    imem_data  = d;
    n = 0;
    @(negedge clock);
    while (clock_counter !== 2'b00 && n < 8) begin
      @(negedge clock);
      n++;
    end
    if (clock_counter !== 2'b00) begin
      total++;
      bad++;
      $display("FAIL exec_reach_wb got cc=%b want 00", clock_counter);
    end
    imem_ready = 1'b0;
    branch = br; branch_taken = tk; jump = jmp; pcrs = prs; rs_value = rsv; halt = hlt;
    @(negedge clock);
    branch = 0; branch_taken = 0; jump = 0; pcrs = 0; rs_value = 32'h0; halt = 0;
  endtask

  task automatic test_reset;
    @(negedge clock);
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got %h want 0", pc); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL reset_instr got %h want 0", instr); end
    total++; if (clock_counter !== 2'b01) begin bad++; $display("FAIL reset_cc got %b want 01", clock_counter); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got %b want 0", imem_req); end
    reset = 1'b0;
    #1;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL release_req got %b want 1", imem_req); end
  endtask

  task automatic test_sequence;
    logic [1:0] exp_cc [4];
    exp_cc = '{2'b10, 2'b11, 2'b00, 2'b01};
    imem_ready = 1'b1;
    imem_data  = 32'h2001_0005;
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL seq_addr got %h want 0", imem_addr); end
    total++; if (clock_counter !== 2'b01) begin bad++; $display("FAIL seq_cc0 got %b want 01", clock_counter); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (i == 0) begin
        total++; if (op !== 6'h08) begin bad++; $display("FAIL seq_op got %h want 08", op); end
        total++; if (instr !== 32'h2001_0005) begin bad++; $display("FAIL seq_instr got %h want 20010005", instr); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL seq_req_exec got %b want 0", imem_req); end
      end
      if (i == 2) imem_ready = 1'b0;
      total++; if (clock_counter !== exp_cc[i]) begin bad++; $display("FAIL seq_cc%0d got %b want %b", i + 1, clock_counter, exp_cc[i]); end
    end
    total++; if (pc !== 32'h4) begin bad++; $display("FAIL seq_pc got %h want 4", pc); end
    total++; if (imem_addr !== 32'h4) begin bad++; $display("FAIL seq_addr2 got %h want 4", imem_addr); end
    total++; if (pc_plus4 !== 32'h8) begin bad++; $display("FAIL seq_pc_plus4 got %h want 8", pc_plus4); end
  endtask

  task automatic test_stall;
    imem_ready = 1'b0;
    imem_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      total++; if (clock_counter !== 2'b01) begin bad++; $display("FAIL stall_cc%0d got %b want 01", i, clock_counter); end
      total++; if (instr !== 32'h2001_0005) begin bad++; $display("FAIL stall_instr%0d got %h want 20010005", i, instr); end
      if (i == 3) begin
        imem_ready = 1'b1;
        imem_data  = 32'h8C00_0000;
      end
      @(negedge clock);
    end
    total++; if (clock_counter !== 2'b10) begin bad++; $display("FAIL stall_exit_cc got %b want 10", clock_counter); end
    total++; if (instr !== 32'h8C00_0000) begin bad++; $display("FAIL stall_instr_new got %h want 8c000000", instr); end
    imem_data = 32'h1234_5678;
    @(negedge clock);
    total++; if (instr !== 32'h8C00_0000) begin bad++; $display("FAIL ready_ignored got %h want 8c000000", instr); end
    imem_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    total++; if (pc !== 32'h8) begin bad++; $display("FAIL stall_pc got %h want 8", pc); end
  endtask

  task automatic test_branch;
    exec_instr(32'h0000_0008, 0, 0, 0, 1, 32'h0000_0100, 0);
    total++; if (pc !== 32'h100) begin bad++; $display("FAIL jr_pc got %h want 100", pc); end
    exec_instr(32'h1000_FFFE, 1, 1, 0, 0, 32'h0, 0);
    total++; if (pc !== 32'hFC) begin bad++; $display("FAIL br_taken got %h want fc", pc); end
    exec_instr(32'h0000_0008, 0, 0, 0, 1, 32'h0000_0100, 0);
    exec_instr(32'h1000_FFFE, 1, 0, 0, 0, 32'h0, 0);
    total++; if (pc !== 32'h104) begin bad++; $display("FAIL br_not_taken got %h want 104", pc); end
  endtask

  task automatic test_jump;
    exec_instr(32'h0000_0008, 0, 0, 0, 1, 32'h1000_0040, 0);
    exec_instr(32'h0800_0010, 0, 0, 1, 0, 32'h0, 0);
    total++; if (pc !== 32'h1000_0040) begin bad++; $display("FAIL jump_pc got %h want 10000040", pc); end
    exec_instr(32'h0800_0010, 0, 0, 1, 1, 32'h0000_0200, 0);
    total++; if (pc !== 32'h200) begin bad++; $display("FAIL pcrs_over_jump got %h want 200", pc); end
  endtask

  task automatic test_wrap;
    exec_instr(32'h0000_0008, 0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    exec_instr(32'h2001_0005, 0, 0, 0, 0, 32'h0, 0);
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap_pc got %h want 0", pc); end
    total++; if (pc_plus4 !== 32'h4) begin bad++; $display("FAIL wrap_pc_plus4 got %h want 4", pc_plus4); end
  endtask

  task automatic test_reset_mid;
    exec_instr(32'h0000_0008, 0, 0, 0, 1, 32'h0000_0040, 0);
    imem_ready = 1'b1;
    imem_data  = 32'hAC00_0000;
    @(negedge clock);
    @(negedge clock);
    total++; if (clock_counter !== 2'b11) begin bad++; $display("FAIL mid_mem_cc got %b want 11", clock_counter); end
    #2 reset = 1'b1;
    #1;
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL mem_rst_pc got %h want 0", pc); end
    total++; if (clock_counter !== 2'b01) begin bad++; $display("FAIL mem_rst_cc got %b want 01", clock_counter); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL mem_rst_instr got %h want 0", instr); end
    @(negedge clock);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL mem_rst_req got %b want 0", imem_req); end
    reset = 1'b0;
    exec_instr(32'h0000_0008, 0, 0, 0, 1, 32'h0000_0080, 0);
    imem_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    total++; if (pc !== 32'h80) begin bad++; $display("FAIL stall_pre_pc got %h want 80", pc); end
    reset = 1'b1;
    #1;
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL stall_rst_pc got %h want 0", pc); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_rst_req got %b want 0", imem_req); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_halt;
    exec_instr(32'h2001_0005, 0, 0, 0, 0, 32'h0, 1);
    total++; if (pc !== 32'h4) begin bad++; $display("FAIL halt_pc got %h want 4", pc); end
    imem_ready = 1'b1;
    imem_data  = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      total++; if (clock_counter !== 2'b10) begin bad++; $display("FAIL halt_cc%0d got %b want 10", i, clock_counter); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL halt_req%0d got %b want 0", i, imem_req); end
      total++; if (instr !== 32'h2001_0005) begin bad++; $display("FAIL halt_instr%0d got %h want 20010005", i, instr); end
      @(negedge clock);
    end
    total++; if (pc !== 32'h4) begin bad++; $display("FAIL halt_pc_hold got %h want 4", pc); end
    reset = 1'b1;
    #1;
    total++; if (clock_counter !== 2'b01) begin bad++; $display("FAIL halt_rst_cc got %b want 01", clock_counter); end
    @(negedge clock);
    reset = 1'b0;
    imem_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    imem_ready = 1'b0; imem_data = 32'h0;
    branch = 0; branch_taken = 0; jump = 0; pcrs = 0; halt = 0; rs_value = 32'h0;
    test_reset;
    test_sequence;
    test_stall;
    test_branch;
    test_jump;
    test_wrap;
    test_reset_mid;
    test_halt;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Front end of the multicycle CPU, directly upstream of the control decoder.
- Owns the PC, the instruction register and the 2-bit phase counter.
- Drives `op` and `clock_counter` into control; consumes control's Branch/Jump/PCrs and the ALU compare result to compute the next PC.
- Stalls the fetch phase until instruction memory answers.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_WIDTH, 32, width of the PC, instruction and rs datapath.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high.
- imem_req  out  1  fetch request; high throughout the FETCH phase.
- imem_addr  out  PC_WIDTH  current PC.
- imem_ready  in  1  imem_data valid this cycle.
- imem_data  in  32  fetched instruction word.
- branch  in  1  Branch from control.
- branch_taken  in  1  compare result from the ALU (beq/bne/blt/ble already resolved).
- jump  in  1  Jump from control.
- pcrs  in  1  PCrs from control (jr).
- rs_value  in  PC_WIDTH  register rs contents for jr.
- halt  in  1  stop request, sampled at end of WB.
- instr  out  32  instruction register.
- op  out  6  instr[31:26].
- clock_counter  out  2  phase code to control.
- pc  out  PC_WIDTH  PC of the instruction in flight.
- pc_plus4  out  PC_WIDTH  pc+4, used as the jal link value.

Behaviour:
- Reset (async, any time, including mid-stall):
  - pc=RESET_PC, instr=0, state=FETCH, clock_counter=2'b01, imem_req=0 while reset is high.
- State machine and clock_counter encoding:
  - FETCH=2'b01, EXEC=2'b10, MEM=2'b11, WB=2'b00, HALTED reports 2'b10.
  - Control asserts MemWrite only at 2'b11 and RegWrite only at 2'b00. Neither occurs in FETCH, EXEC or HALTED.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On a rising edge with imem_ready=1: instr<=imem_data, go to EXEC.
  - Otherwise hold FETCH; instr and pc unchanged. Stall length is unbounded.
  - imem_ready in the first FETCH cycle gives single-cycle fetch, so minimum instruction latency is 4 cycles.
  - imem_ready outside FETCH is ignored.
- EXEC -> MEM -> WB: unconditional, one cycle each.
- WB edge (WB -> FETCH), pc is updated using this priority:
  1. pcrs: pc<=rs_value.
  2. jump: pc<={pc_plus4[31:28], instr[25:0], 2'b00}.
  3. branch && branch_taken: pc<=pc_plus4 + (sign_extend(instr[15:0])<<2).
  4. otherwise pc<=pc_plus4.
- Control inputs (branch, jump, pcrs, rs_value, branch_taken) are sampled only on the WB edge and are don't-care elsewhere.
- Simultaneous pcrs and jump: pcrs wins.
- Arithmetic wraps modulo 2^PC_WIDTH; no overflow flag.
- halt=1 on the WB edge: pc is still updated as above, then state goes to HALTED instead of FETCH.
- HALTED: imem_req=0, instr held; exit only by reset.
- pc_plus4 = pc+4, combinational.
- op = instr[31:26], combinational.

Decomposition:
- Phase codes go in config.v alongside the existing opcode and ALUop macros:
  - `PHASE_FETCH=2'b01, `PHASE_EXEC=2'b10, `PHASE_MEM=2'b11, `PHASE_WB=2'b00, `PHASE_HALT=2'b10.
  - Control and this block share them.
- One combinational sub-module, pc_next_sel:
  - Inputs: pc_plus4, instr, rs_value, branch, branch_taken, jump, pcrs.
  - Output: next_pc.
  - Implements the priority mux so it can be unit-tested in isolation.

Test Plan:
- Reset release, imem_ready tied 1, imem_data=32'h2001_0005 (addi) → imem_addr=0 in FETCH; clock_counter sequence 01,10,11,00,01; pc=4 at second FETCH; op=6'h08.
- imem_ready held low 3 cycles in FETCH → clock_counter stays 01 for 4 cycles; instr unchanged until the ready edge.
- pc=32'h100, instr imm=16'hFFFE, branch=1, branch_taken=1 at WB → pc=32'hFC. With branch_taken=0 → pc=32'h104.
- pc=32'h1000_0040, jump=1, instr[25:0]=26'h0000010 → pc=32'h1000_0040; pcrs=1 and jump=1 with rs_value=32'h200 → pc=32'h200.
- pc=32'hFFFF_FFFC, sequential → pc wraps to 0, pc_plus4 of the new pc =4.
- Reset asserted mid-MEM and mid-stall; halt=1 at WB → immediately pc=RESET_PC, clock_counter=01, imem_req low while reset high; after halt, clock_counter=10 and imem_req=0 indefinitely.
